instr_fetch_unit: RTL and testbench

- Instruction-fetch stage of the MIPS core; sits directly upstream of the main decoder and supplies its Opcode field.
- Holds the PC and issues requests to instruction memory over a req/ack handshake, then presents the fetched word until the datapath retires it.
- Consumes Jump, Branch and ALU Zero at retirement to select the next PC: sequential, branch target or jump target.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/next_pc_logic.sv | 31 +++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: opcode encodings, the fetch-stage
// state type, the default reset PC and a branch-offset helper.
package mips_pkg;

  // Primary opcode field values (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // PC loaded when the core comes out of reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // FETCH: request outstanding to instruction memory.
  // HOLD : fetched word presented to the datapath until retired.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Sign-extend a 16-bit branch immediate and turn it into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Purely combinational next-PC selection: jump target, taken-branch target
// or the sequential address. Jump has priority over branch.
module next_pc_logic
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  // Only the low 26 bits of the instruction feed target arithmetic.
  input  logic [25:0]       instr,
  input  logic              jump,
  input  logic              branch,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  // Select the next PC; all adds wrap modulo 2^ADDR_W.
  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // branch, so no path can leave it unassigned and infer a latch.
    pc_plus4 = pc + ADDR_W'(4);
    next_pc  = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[ADDR_W-1:ADDR_W-4], instr[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the fetched word until the datapath retires it, then steps the PC.
// Optional build macro FETCH_PERF_CNT_EN adds retired/stall counters.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic              branch,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic              req_en_q;
  logic              load_instr;
  logic              advance_pc;
  logic [ADDR_W-1:0] next_pc;

  // Requests stay off until the first edge after reset release, so an ack
  // from a request aborted by reset can never be captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_en_q <= 1'b0;
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    else     req_en_q <= 1'b1;
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake decode.
  always_comb begin
    state_d    = state_q;
    load_instr = 1'b0;
    advance_pc = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (imem_req && imem_ack) begin
          load_instr = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          advance_pc = 1'b1;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Instruction register: captured on ack, held stable while in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             instr_q <= 32'h0;
    else if (load_instr) instr_q <= imem_rdata;
  end

  // Program counter: steps only when the current instruction retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pc_q <= RESET_PC[ADDR_W-1:0];
    else if (advance_pc) pc_q <= next_pc;
  end

  next_pc_logic #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc       (pc_q),
    .instr    (instr_q[25:0]),
    .jump     (jump),
    .branch   (branch),
    .zero     (zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  assign imem_req    = req_en_q && (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = (state_q == HOLD);

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: retirements and request cycles without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= 32'h0;
      stall_cnt   <= 32'h0;
    end else begin
      if (advance_pc)            retired_cnt <= retired_cnt + 32'd1;
      if (imem_req && !imem_ack) stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit. Expected addresses and
// opcodes are hand-computed. Honours FETCH_PERF_CNT_EN for the counters.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One fetch/retire round trip. Entered 1 time unit after a rising edge
  // with the DUT expected in FETCH at address addr.
  task automatic do_fetch(input string tag, input logic [31:0] addr,
                          input logic [31:0] word, input int delay,
                          input int hold, input logic j, input logic b,
                          input logic z);
    logic [31:0] exp_op;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall0;
    stall0 = stall_cnt;
`endif
    exp_op      = {26'd0, word[31:26]};
    instr_ready = 1'b1;
    imem_ack    = 1'b0;
    check({tag, ".req"},   32'(imem_req),    32'd1);
    check({tag, ".addr"},  imem_addr,        addr);
    check({tag, ".valid"}, 32'(instr_valid), 32'd0);
    repeat (delay) begin
      @(posedge clk); #1;
      check({tag, ".wait_valid"}, 32'(instr_valid), 32'd0);
      check({tag, ".wait_req"},   32'(imem_req),    32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check({tag, ".hold_valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".hold_req"},   32'(imem_req),    32'd0);
    check({tag, ".instr"},      instr,            word);
    check({tag, ".opcode"},     {26'd0, opcode},  exp_op);
    check({tag, ".pc"},         pc,               addr);
    check({tag, ".pc_plus4"},   pc_plus4,         addr + 32'd4);
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".stall"}, stall_cnt - stall0, 32'(delay));
`endif
    if (hold > 0) begin
      instr_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        check({tag, ".held_instr"}, instr,            word);
        check({tag, ".held_valid"}, 32'(instr_valid), 32'd1);
      end
      instr_ready = 1'b1;
    end
    jump   = j;
    branch = b;
    zero   = z;
    @(posedge clk); #1;
    jump   = 1'b0;
    branch = 1'b0;
    zero   = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;

    // Reset state.
    #12;
    check("rst.req",   32'(imem_req),    32'd0);
    check("rst.valid", 32'(instr_valid), 32'd0);
    check("rst.pc",    pc,               32'h0);
    check("rst.instr", instr,            32'h0);
    #10 rst = 1'b0;
    #1;
    check("rel.req_before_edge", 32'(imem_req), 32'd0);
    @(posedge clk); #1;

    // Sequential stream, zero-latency acks, ready held high.
    do_fetch("seq0", 32'h0000_0000, 32'h2001_0005, 0, 0, 1'b0, 1'b0, 1'b0);
    do_fetch("seq1", 32'h0000_0004, 32'h8C22_0000, 0, 1, 1'b0, 1'b0, 1'b0);
    do_fetch("seq2", 32'h0000_0008, 32'hAC22_0004, 0, 0, 1'b0, 1'b0, 1'b0);
    // Slow memory: two request cycles without ack.
    do_fetch("slow", 32'h0000_000C, 32'h0022_1820, 2, 0, 1'b0, 1'b0, 1'b0);
    // J 0x10 -> 0x40.
    do_fetch("j40",  32'h0000_0010, 32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b0);
    // BEQ -2 taken at 0x40 -> 0x3C.
    do_fetch("beqt", 32'h0000_0040, 32'h1022_FFFE, 0, 0, 1'b0, 1'b1, 1'b1);
    // J 0x10 back to 0x40.
    do_fetch("jbk",  32'h0000_003C, 32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b0);
    // BEQ -2 not taken at 0x40 -> 0x44.
    do_fetch("beqn", 32'h0000_0040, 32'h1022_FFFE, 0, 0, 1'b0, 1'b1, 1'b0);
    // J all-ones target -> 0x0FFF_FFFC.
    do_fetch("jhi",  32'h0000_0044, 32'h0BFF_FFFF, 0, 0, 1'b1, 1'b0, 1'b0);
    // Sequential across the 256 MB region boundary.
    do_fetch("xing", 32'h0FFF_FFFC, 32'h2001_0005, 0, 0, 1'b0, 1'b0, 1'b0);
    do_fetch("r1s0", 32'h1000_0000, 32'h8C22_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    do_fetch("r1s1", 32'h1000_0004, 32'hAC22_0004, 0, 0, 1'b0, 1'b0, 1'b0);
    // J 0x100 with branch&zero also set: jump wins -> 0x1000_0400.
    do_fetch("jbz",  32'h1000_0008, 32'h0800_0100, 0, 0, 1'b1, 1'b1, 1'b1);

    // Reset during FETCH with an ack pending.
    check("mid.req",  32'(imem_req), 32'd1);
    check("mid.addr", imem_addr,     32'h1000_0400);
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C22_0000;
    #2 rst = 1'b1;
    #1;
    check("mid.rst_req",   32'(imem_req),    32'd0);
    check("mid.rst_valid", 32'(instr_valid), 32'd0);
    check("mid.rst_pc",    pc,               32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid.rel_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    check("mid.stale_ack_valid", 32'(instr_valid), 32'd0);
    check("mid.restart_req",     32'(imem_req),    32'd1);
    check("mid.restart_addr",    imem_addr,        32'h0);
    check("mid.restart_instr",   instr,            32'h0);
    imem_ack = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    check("mid.retired_clr", retired_cnt, 32'd0);
    check("mid.stall_clr",   stall_cnt,   32'd0);
`endif

    // BEQ -2 taken at 0 wraps to 0xFFFF_FFFC, then sequential wraps to 0.
    do_fetch("wrapb", 32'h0000_0000, 32'h1022_FFFE, 0, 0, 1'b0, 1'b1, 1'b1);
    do_fetch("top",   32'hFFFF_FFFC, 32'h2001_0005, 0, 0, 1'b0, 1'b0, 1'b0);
    check("wrap.addr", imem_addr,     32'h0);
    check("wrap.req",  32'(imem_req), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("end.retired", retired_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
